bf_prog_mem: RTL and testbench

- Writable, parametrised program memory for the brainfuck CPU.
- Holds 3-bit opcodes fetched by the core.
- A byte-stream loader (fed from UART/host) accepts ASCII program text, drops comment characters, stores opcodes, checks bracket balance and records program length.
- Read port: one-cycle registered fetch with a per-read overrun flag, so the core halts cleanly at end of program.

---
 rtl/bf_prog_mem.sv | 230 +++++++++++++++++++++++
 tb/tb_bf_prog_mem.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_prog_mem.sv
// Brainfuck program memory: ASCII byte loader with bracket checking plus a registered fetch port.
// Optional macro BF_BOOT_PROG_EN: reset selects a built-in 18-opcode boot image until the next load.
module bf_prog_mem #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int NEST_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic [1:0]        load_err,
    output logic [ADDR_W:0]   prog_len,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [2:0]        rd_code,
    output logic              rd_valid,
    output logic              rom_overrun
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    localparam int                MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   PTR_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   PTR_ZERO  = (ADDR_W + 1)'(0);
    localparam logic [NEST_W-1:0] NEST_MAX  = {NEST_W{1'b1}};
    localparam logic [NEST_W-1:0] NEST_ZERO = {NEST_W{1'b0}};
    localparam logic [NEST_W-1:0] NEST_ONE  = NEST_W'(1);
    localparam logic [2:0]        OP_OPEN   = 3'b011;
    localparam logic [2:0]        OP_CLOSE  = 3'b010;
    localparam logic [1:0]        ERR_NONE  = 2'b00;
    localparam logic [1:0]        ERR_OVF   = 2'b01;
    localparam logic [1:0]        ERR_CLOSE = 2'b10;
    localparam logic [1:0]        ERR_OPEN  = 2'b11;

    // {is_opcode, opcode}; anything that is not one of the eight commands is a comment
    function automatic logic [3:0] decode_op(input logic [7:0] ch);
        case (ch)
            8'h2B:   decode_op = 4'b1_111;
            8'h2D:   decode_op = 4'b1_110;
            8'h3E:   decode_op = 4'b1_101;
            8'h3C:   decode_op = 4'b1_100;
            8'h5B:   decode_op = 4'b1_011;
            8'h5D:   decode_op = 4'b1_010;
            8'h2E:   decode_op = 4'b1_001;
            8'h2C:   decode_op = 4'b1_000;
            default: decode_op = 4'b0_000;
        endcase
    endfunction

`ifdef BF_BOOT_PROG_EN
    localparam logic [ADDR_W:0] BOOT_LEN_L = (ADDR_W + 1)'(18);

    // Boot image "++[>++[>++<-]<-]>>"
    function automatic logic [2:0] boot_op(input logic [4:0] idx);
        case (idx)
            5'd0, 5'd1, 5'd4, 5'd5, 5'd8, 5'd9: boot_op = 3'b111;
            5'd2, 5'd6:                         boot_op = 3'b011;
            5'd3, 5'd7, 5'd16, 5'd17:           boot_op = 3'b101;
            5'd10, 5'd13:                       boot_op = 3'b100;
            5'd11, 5'd14:                       boot_op = 3'b110;
            5'd12, 5'd15:                       boot_op = 3'b010;
            default:                            boot_op = 3'b000;
        endcase
    endfunction

    logic boot_sel_q, boot_sel_d;
`endif

    logic [2:0]        mem_q [DEPTH];
    state_e            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [NEST_W-1:0] nest_q, nest_d;
    logic [1:0]        load_err_q, load_err_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              load_done_q, load_done_d;
    logic              rd_valid_q, rd_valid_d;
    logic [2:0]        rd_code_q, rd_code_d;
    logic              rom_overrun_q, rom_overrun_d;
    logic [3:0]        op_s;
    logic [1:0]        ld_err_s;
    logic              mem_we_s;
    logic              rd_ovr_s;
    logic [2:0]        rd_word_s;

    // State register plus all loader and fetch-port flops
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef BF_BOOT_PROG_EN
            state_q    <= ST_READY;
            prog_len_q <= BOOT_LEN_L;
            boot_sel_q <= 1'b1;
`else
            state_q    <= ST_IDLE;
            prog_len_q <= PTR_ZERO;
`endif
            wr_ptr_q      <= PTR_ZERO;
            nest_q        <= NEST_ZERO;
            load_err_q    <= ERR_NONE;
            load_done_q   <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_code_q     <= 3'b000;
            rom_overrun_q <= 1'b1;
        end else begin
`ifdef BF_BOOT_PROG_EN
            boot_sel_q <= boot_sel_d;
`endif
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            nest_q        <= nest_d;
            load_err_q    <= load_err_d;
            prog_len_q    <= prog_len_d;
            load_done_q   <= load_done_d;
            rd_valid_q    <= rd_valid_d;
            rd_code_q     <= rd_code_d;
            rom_overrun_q <= rom_overrun_d;
        end
    end

    // Opcode storage; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_q[wr_ptr_q[MEM_AW-1:0]] <= op_s[2:0];
        end
    end

    // Next state: load_start wins over any same-cycle byte, errors win over completion
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        nest_d      = nest_q;
        load_err_d  = load_err_q;
        prog_len_d  = prog_len_q;
        load_done_d = 1'b0;
        mem_we_s    = 1'b0;
        ld_err_s    = ERR_NONE;
        op_s        = decode_op(ld_data);
`ifdef BF_BOOT_PROG_EN
        boot_sel_d  = boot_sel_q;
`endif
        if (load_start) begin
            state_d    = ST_LOAD;
            wr_ptr_d   = PTR_ZERO;
            nest_d     = NEST_ZERO;
            load_err_d = ERR_NONE;
            prog_len_d = PTR_ZERO;
`ifdef BF_BOOT_PROG_EN
            boot_sel_d = 1'b0;
`endif
        end else if (state_q == ST_LOAD && ld_valid) begin
            if (!op_s[3]) begin
                ld_err_s = ERR_NONE;
            end else if (wr_ptr_q == DEPTH_L) begin
                ld_err_s = ERR_OVF;
            end else if (op_s[2:0] == OP_OPEN && nest_q == NEST_MAX) begin
                ld_err_s = ERR_OPEN;
            end else if (op_s[2:0] == OP_CLOSE && nest_q == NEST_ZERO) begin
                ld_err_s = ERR_CLOSE;
            end else begin
                mem_we_s = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (op_s[2:0] == OP_OPEN) begin
                    nest_d = nest_q + NEST_ONE;
                end else if (op_s[2:0] == OP_CLOSE) begin
                    nest_d = nest_q - NEST_ONE;
                end else begin
                    nest_d = nest_q;
                end
            end
            if (ld_err_s != ERR_NONE) begin
                state_d    = ST_ERROR;
                load_err_d = ld_err_s;
                prog_len_d = PTR_ZERO;
            end else if (ld_last && nest_d == NEST_ZERO) begin
                state_d     = ST_READY;
                prog_len_d  = wr_ptr_d;
                load_done_d = 1'b1;
            end else if (ld_last) begin
                state_d    = ST_ERROR;
                load_err_d = ERR_OPEN;
                prog_len_d = PTR_ZERO;
            end else begin
                state_d = ST_LOAD;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Fetch port: overrun is judged against the program in force when rd_en is seen
    always_comb begin
        rd_valid_d = rd_en;
        rd_ovr_s   = (state_q != ST_READY) || ({1'b0, rd_addr} >= prog_len_q);
        rd_word_s  = mem_q[rd_addr[MEM_AW-1:0]];
`ifdef BF_BOOT_PROG_EN
        if (boot_sel_q) begin
            rd_ovr_s  = ({1'b0, rd_addr} >= BOOT_LEN_L);
            rd_word_s = boot_op(5'(rd_addr));
        end else begin
            rd_word_s = mem_q[rd_addr[MEM_AW-1:0]];
        end
`endif
        if (rd_en) begin
            rd_code_d     = rd_ovr_s ? 3'b000 : rd_word_s;
            rom_overrun_d = rd_ovr_s;
        end else begin
            rd_code_d     = rd_code_q;
            rom_overrun_d = rom_overrun_q;
        end
    end

    assign ld_ready    = (state_q == ST_LOAD);
    assign load_busy   = (state_q == ST_LOAD);
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;
    assign prog_len    = prog_len_q;
    assign rd_valid    = rd_valid_q;
    assign rd_code     = rd_code_q;
    assign rom_overrun = rom_overrun_q;
endmodule

// File: tb/tb_bf_prog_mem.sv
// Randomized self-checking bench for bf_prog_mem against a string/array level reference model.
module tb_bf_prog_mem;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int NEST_W = 8;
    localparam int M_IDLE = 0, M_LOAD = 1, M_READY = 2, M_ERROR = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic              ld_valid = 1'b0;
    logic [7:0]        ld_data = 8'h00;
    logic              ld_last = 1'b0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              ld_ready, load_busy, load_done, rd_valid, rom_overrun;
    logic [1:0]        load_err;
    logic [ADDR_W:0]   prog_len;
    logic [2:0]        rd_code;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;
    bit rand_rd = 1'b0;

    bf_prog_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NEST_W(NEST_W)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .load_busy(load_busy),
        .load_done(load_done), .load_err(load_err), .prog_len(prog_len), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_code(rd_code), .rd_valid(rd_valid), .rom_overrun(rom_overrun)
    );

    always #5 clk = ~clk;

    // Reference model: opcode value is the position of the command in this string
    string ops      = ",.][<>-+";
    string boot_img = "++[>++[>++<-]<-]>>";
    int m_state = M_IDLE, m_wr = 0, m_nest = 0, m_err = 0, m_len = 0, m_rc = 0;
    bit m_done = 1'b0, m_rv = 1'b0, m_ro = 1'b1, m_boot = 1'b0;
    int m_mem [DEPTH];

    function automatic int op_of(byte c);
        for (int i = 0; i < 8; i++) if (ops[i] == c) return i;
        return -1;
    endfunction

    always @(posedge clk) begin : model
        automatic int st = m_state, wr = m_wr, nest = m_nest, err = m_err, len = m_len;
        automatic bit done = 1'b0, boot = m_boot, ovr = 1'b0;
        automatic int op = -1, bad = 0;
        if (rst) begin
            st = M_IDLE; len = 0; boot = 1'b0;
`ifdef BF_BOOT_PROG_EN
            st = M_READY; len = 18; boot = 1'b1;
`endif
            wr = 0; nest = 0; err = 0;
            m_rv <= 1'b0; m_rc <= 0; m_ro <= 1'b1;
        end else begin
            if (rd_en) begin
                if (m_boot) ovr = (int'(rd_addr) >= 18);
                else        ovr = (m_state != M_READY) || (int'(rd_addr) >= m_len);
                m_rv <= 1'b1;
                m_ro <= ovr;
                m_rc <= ovr ? 0 : (m_boot ? op_of(boot_img[int'(rd_addr)]) : m_mem[int'(rd_addr)]);
            end else begin
                m_rv <= 1'b0;
            end
            if (load_start) begin
                st = M_LOAD; wr = 0; nest = 0; err = 0; len = 0; boot = 1'b0;
            end else if (m_state == M_LOAD && ld_valid) begin
                op = op_of(ld_data);
                if (op >= 0) begin
                    if (wr == DEPTH)                               bad = 1;
                    else if (op == 3 && nest == (1 << NEST_W) - 1) bad = 3;
                    else if (op == 2 && nest == 0)                 bad = 2;
                    else begin
                        m_mem[wr] <= op;
                        wr = wr + 1;
                        nest = nest + (op == 3 ? 1 : 0) - (op == 2 ? 1 : 0);
                    end
                end
                if (bad != 0) begin
                    st = M_ERROR; err = bad; len = 0;
                end else if (ld_last) begin
                    if (nest == 0) begin st = M_READY; len = wr; done = 1'b1; end
                    else begin st = M_ERROR; err = 3; len = 0; end
                end
            end
        end
        m_state <= st; m_wr <= wr; m_nest <= nest; m_err <= err;
        m_len <= len; m_done <= done; m_boot <= boot;
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_on) begin
            n_tests++;
            if (ld_ready !== (m_state == M_LOAD) || load_busy !== (m_state == M_LOAD) ||
                load_done !== m_done || load_err !== 2'(m_err) || prog_len !== (ADDR_W + 1)'(m_len) ||
                rd_valid !== m_rv || rd_code !== 3'(m_rc) || rom_overrun !== m_ro) begin
                n_fail++;
                $display("FAIL cycle @%0t: dut rdy=%b busy=%b done=%b err=%b len=%0d rv=%b code=%b ovr=%b; model rdy=%b done=%b err=%0d len=%0d rv=%b code=%0d ovr=%b",
                         $time, ld_ready, load_busy, load_done, load_err, prog_len, rd_valid, rd_code,
                         rom_overrun, m_state == M_LOAD, m_done, m_err, m_len, m_rv, m_rc, m_ro);
            end
        end
    end

    task automatic cyc();
        if (rand_rd) begin
            rd_en   = 1'($urandom_range(1, 0));
            rd_addr = ADDR_W'($urandom_range(3, 0) == 0 ? $urandom_range(255, 0) : $urandom_range(24, 0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_bytes(input byte q[$], input int gap_pct, output bit done_seen);
        done_seen = 1'b0;
        load_start = 1'b1; cyc(); load_start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            for (int k = 0; k < 3 && $urandom_range(99, 0) < gap_pct; k++) begin
                ld_valid = 1'b0; cyc();
            end
            ld_valid = 1'b1; ld_data = q[i]; ld_last = (i == q.size() - 1); cyc();
        end
        done_seen = load_done;
        ld_valid = 1'b0; ld_last = 1'b0; cyc();
    endtask

    function automatic void str_q(input string s, output byte q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endfunction

    task automatic rd(input int a, output int code, output int ovr, output int vld);
        rd_en = 1'b1; rd_addr = ADDR_W'(a); cyc(); rd_en = 1'b0;
        code = int'(rd_code); ovr = int'(rom_overrun); vld = int'(rd_valid);
    endtask

    function automatic void gen_prog(output byte q[$]);
        automatic string alpha = "+-<>.,ab \n";
        automatic int n = $urandom_range(14, 1);
        automatic int d = 0;
        automatic bit bal = ($urandom_range(3, 0) != 0);
        q = {};
        for (int i = 0; i < n; i++) begin
            automatic int r = $urandom_range(9, 0);
            if (r < 2) begin q.push_back(8'h5B); d++; end
            else if (r < 4 && (!bal || d > 0)) begin q.push_back(8'h5D); d--; end
            else q.push_back(alpha[$urandom_range(alpha.len() - 1, 0)]);
        end
        while (bal && d > 0) begin q.push_back(8'h5D); d--; end
    endfunction

    int  exp_a [6]  = '{7, 7, 3, 6, 2, 1};
    int  boot_e [18] = '{7, 7, 3, 5, 7, 7, 3, 5, 7, 7, 4, 6, 2, 4, 6, 2, 5, 5};
    byte q [$];
    bit  dn;
    int  c, o, v;

    initial begin
        cyc(); cyc();
        rst = 1'b0;
        chk_on = 1'b1;
        check("reset_err", int'(load_err), 0);
        check("reset_rvalid", int'(rd_valid), 0);
        check("reset_code", int'(rd_code), 0);
        check("reset_overrun", int'(rom_overrun), 1);
        check("reset_ready", int'(ld_ready), 0);
`ifdef BF_BOOT_PROG_EN
        check("reset_len", int'(prog_len), 18);
        for (int i = 0; i < 18; i++) begin
            rd(i, c, o, v);
            check("boot_code", c, boot_e[i]);
            check("boot_ovr", o, 0);
        end
        rd(18, c, o, v);
        check("boot_ovr18", o, 1);
        str_q(".", q); load_bytes(q, 0, dn);
        check("boot_then_load_len", int'(prog_len), 1);
        rd(0, c, o, v);
        check("boot_then_load_code", c, 1);
`else
        check("reset_len", int'(prog_len), 0);
`endif
        str_q("++[-].", q); load_bytes(q, 30, dn);
        check("basic_done", int'(dn), 1);
        check("basic_len", int'(prog_len), 6);
        for (int i = 0; i < 6; i++) begin
            rd(i, c, o, v);
            check("basic_valid", v, 1);
            check("basic_code", c, exp_a[i]);
            check("basic_ovr", o, 0);
        end
        rd(6, c, o, v);
        check("basic_ovr6", o, 1);
        check("basic_code6", c, 0);

        str_q("a+ b\n-", q); load_bytes(q, 0, dn);
        check("comment_len", int'(prog_len), 2);
        rd(0, c, o, v); check("comment_code0", c, 7);
        rd(1, c, o, v); check("comment_code1", c, 6);

        str_q("+]", q); load_bytes(q, 0, dn);
        check("unmatched_close", int'(load_err), 2);
        str_q("[[+]", q); load_bytes(q, 0, dn);
        check("unclosed_open", int'(load_err), 3);
        check("unclosed_len", int'(prog_len), 0);
        load_start = 1'b1; cyc(); load_start = 1'b0;
        check("err_cleared", int'(load_err), 0);

        q = {};
        for (int i = 0; i < DEPTH + 1; i++) q.push_back(8'h2B);
        load_bytes(q, 0, dn);
        check("overflow_err", int'(load_err), 1);
        check("overflow_len", int'(prog_len), 0);
        rd(0, c, o, v); check("overflow_ovr", o, 1);

        q = {};
        for (int i = 0; i < (1 << NEST_W); i++) q.push_back(8'h5B);
        load_bytes(q, 0, dn);
        check("nest_max_err", int'(load_err), 3);

        str_q("" , q);
        q.push_back(8'h61);
        load_bytes(q, 0, dn);
        check("empty_done", int'(dn), 1);
        check("empty_len", int'(prog_len), 0);

        load_start = 1'b1; cyc(); load_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'h2B; cyc(); cyc();
        ld_valid = 1'b0; rst = 1'b1; cyc(); rst = 1'b0;
        check("midload_rst_ready", int'(ld_ready), 0);
        rd(0, c, o, v);
`ifdef BF_BOOT_PROG_EN
        check("midload_rst_ovr", o, 0);
`else
        check("midload_rst_ovr", o, 1);
`endif

        rand_rd = 1'b1;
        for (int p = 0; p < 80; p++) begin
            gen_prog(q);
            load_bytes(q, $urandom_range(50, 0), dn);
            for (int k = 0; k < 6; k++) cyc();
        end
        rand_rd = 1'b0; rd_en = 1'b0;
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
